// File: rtl/lmi_dram_arb_if.sv
// Bus bundle for lmi_dram_arb: instruction and data requesters plus the DRAM port.
// "master" is the side driving the requests and M_ACK; "slave" is the arbiter.
interface lmi_dram_arb_if;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        I_GNT;
  logic        I_DONE;
  logic        I_ERR;

  logic        D_REQ;
  logic [31:0] D_ADDR;
  logic        D_WR;
  logic        D_GNT;
  logic        D_DONE;
  logic        D_ERR;

  logic        M_REQ;
  logic [31:0] M_ADDR;
  logic        M_WR;
  logic        M_ACK;

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_ADDR, D_WR, M_ACK,
    input  I_GNT, I_DONE, I_ERR, D_GNT, D_DONE, D_ERR, M_REQ, M_ADDR, M_WR
  );

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_ADDR, D_WR, M_ACK,
    output I_GNT, I_DONE, I_ERR, D_GNT, D_DONE, D_ERR, M_REQ, M_ADDR, M_WR
  );
endinterface

// File: rtl/lmi_dram_arb.sv
// Two-requester round-robin DRAM arbiter with BASE/TOP window check.
// Define LMI_DRAM_ARB_TMO_EN to add an XFER timeout that ends a stuck access with ERR.
//
// state | meaning
// IDLE  | sample I_REQ/D_REQ, latch winner's address/WR/owner
// CHK   | owner's GNT high; window check on latched address
// XFER  | M_REQ high with stable M_ADDR/M_WR until M_ACK (or timeout)
// RESP  | owner's DONE pulse (ERR too on miss/timeout); pointer moves on
module lmi_dram_arb #(
  parameter int BASE_LO = 12,
  parameter int TOP_HI  = 23,
  parameter int TOP_LO  = 4,
  parameter int TMO_W   = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [31:BASE_LO]    BASE,
  input  logic [TOP_HI:TOP_LO] TOP,
  lmi_dram_arb_if.slave        bus,
  output logic                 BUSY
);

  typedef enum logic [1:0] {IDLE, CHK, XFER, RESP} state_t;

  state_t      state;
  logic        owner;   // 0 = instruction, 1 = data
  logic        ptr;
  logic [31:0] addr_q;
  logic        wr_q;
  logic        m_req;
  logic        i_gnt, d_gnt, i_done, d_done, i_err, d_err;
  logic        pick;
  logic        hit;

`ifdef LMI_DRAM_ARB_TMO_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    pick = ptr;
    if (bus.I_REQ && !bus.D_REQ)
      pick = 1'b0;
    else if (!bus.I_REQ && bus.D_REQ)
      pick = 1'b1;
  end

  always_comb begin
    hit = (addr_q[31:TOP_HI+1]      == BASE[31:TOP_HI+1]) &&
          (addr_q[TOP_HI:BASE_LO]   >= BASE[TOP_HI:BASE_LO]) &&
          (addr_q[TOP_HI:TOP_LO]    <= TOP);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= IDLE;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      m_req   <= 1'b0;
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_err   <= 1'b0;
      d_err   <= 1'b0;
`ifdef LMI_DRAM_ARB_TMO_EN
      tmo_cnt <= '0;
`endif
    end else begin
      i_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_err  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.I_REQ || bus.D_REQ) begin
            owner  <= pick;
            addr_q <= pick ? bus.D_ADDR : bus.I_ADDR;
            wr_q   <= pick & bus.D_WR;
            i_gnt  <= !pick;
            d_gnt  <= pick;
            state  <= CHK;
          end
        end
        CHK: begin
          if (hit) begin
            m_req   <= 1'b1;
`ifdef LMI_DRAM_ARB_TMO_EN
            tmo_cnt <= '0;
`endif
            state   <= XFER;
          end else begin
            i_done <= !owner;
            d_done <= owner;
            i_err  <= !owner;
            d_err  <= owner;
            state  <= RESP;
          end
        end
        XFER: begin
          // M_ACK takes precedence over a timeout landing in the same cycle.
          if (bus.M_ACK) begin
            m_req  <= 1'b0;
            i_done <= !owner;
            d_done <= owner;
            state  <= RESP;
          end
`ifdef LMI_DRAM_ARB_TMO_EN
          else if (tmo_cnt == TMO_LAST) begin
            m_req  <= 1'b0;
            i_done <= !owner;
            d_done <= owner;
            i_err  <= !owner;
            d_err  <= owner;
            state  <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          ptr   <= !owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.I_GNT  = i_gnt;
  assign bus.D_GNT  = d_gnt;
  assign bus.I_DONE = i_done;
  assign bus.D_DONE = d_done;
  assign bus.I_ERR  = i_err;
  assign bus.D_ERR  = d_err;
  assign bus.M_REQ  = m_req;
  assign bus.M_ADDR = addr_q;
  assign bus.M_WR   = wr_q;
  assign BUSY       = (state != IDLE);

endmodule

// File: tb/tb_lmi_dram_arb.sv
// Scoreboard bench for lmi_dram_arb: directed transactions push expected output
// events (cycle, pulse pattern, DRAM address) that a negedge monitor pops and compares.
module tb_lmi_dram_arb;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:12] base_r;
  logic [23:4]  top_r;
  logic        busy;

  lmi_dram_arb_if bus();

  lmi_dram_arb dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .BASE    (base_r),
    .TOP     (top_r),
    .bus     (bus),
    .BUSY    (busy)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  localparam logic [7:0] E_IG = 8'h80, E_DG = 8'h40, E_ID = 8'h20, E_IE = 8'h10;
  localparam logic [7:0] E_DD = 8'h08, E_DE = 8'h04, E_RISE = 8'h02, E_FALL = 8'h01;

  typedef struct {
    int          cyc;
    logic [7:0]  obs;
    logic [31:0] addr;
    logic        wr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  logic prev_mreq = 1'b0;

  // Monitor: any pulse or M_REQ edge is an event that must match the queue head.
  always @(negedge HCLK) begin
    if (mon_en) begin
      logic [7:0] obs;
      exp_t       e;
      obs = {bus.I_GNT, bus.D_GNT, bus.I_DONE, bus.I_ERR, bus.D_DONE, bus.D_ERR,
             (bus.M_REQ && !prev_mreq), (!bus.M_REQ && prev_mreq)};
      prev_mreq = bus.M_REQ;
      if (obs !== 8'h00) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event cyc=%0d got obs=%h want none", cyc, obs);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || obs !== e.obs ||
              (obs[1] && (bus.M_ADDR !== e.addr || bus.M_WR !== e.wr))) begin
            bad++;
            $display("FAIL event cyc=%0d obs=%h addr=%h wr=%b want cyc=%0d obs=%h addr=%h wr=%b",
                     cyc, obs, bus.M_ADDR, bus.M_WR, e.cyc, e.obs, e.addr, e.wr);
          end
        end
      end
    end
  end

  task automatic push(input int c, input logic [7:0] o, input logic [31:0] a, input logic w);
    exp_t e;
    e.cyc = c; e.obs = o; e.addr = a; e.wr = w;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_req(input bit own_d, input logic [31:0] a, input logic w);
    if (own_d) begin
      bus.D_REQ = 1'b1; bus.D_ADDR = a; bus.D_WR = w;
    end else begin
      bus.I_REQ = 1'b1; bus.I_ADDR = a;
    end
  endtask

  task automatic drop_req();
    bus.I_REQ = 1'b0;
    bus.D_REQ = 1'b0;
  endtask

  // Window hit, M_ACK on the first XFER cycle.
  task automatic hit_xact(input bit own_d, input logic [31:0] a, input logic w);
    int c;
    c = cyc;
    push(c + 1, own_d ? E_DG : E_IG, '0, 1'b0);
    push(c + 2, E_RISE, a, own_d ? w : 1'b0);
    push(c + 3, (own_d ? E_DD : E_ID) | E_FALL, '0, 1'b0);
    drive_req(own_d, a, w);
    step();
    drop_req();
    step();
    check("busy_xfer", {31'd0, busy}, 32'd1);
    bus.M_ACK = 1'b1;
    step();
    bus.M_ACK = 1'b0;
    step();
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // Window miss: DONE+ERR two cycles after the request, no DRAM access.
  task automatic miss_xact(input bit own_d, input logic [31:0] a, input logic w);
    int c;
    c = cyc;
    push(c + 1, own_d ? E_DG : E_IG, '0, 1'b0);
    push(c + 2, own_d ? (E_DD | E_DE) : (E_ID | E_IE), '0, 1'b0);
    drive_req(own_d, a, w);
    step();
    drop_req();
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d events pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    HRESETn = 1'b0;
    base_r = 20'h10000;
    top_r  = 20'h0FFFF;
    bus.I_REQ = 1'b0; bus.I_ADDR = '0;
    bus.D_REQ = 1'b0; bus.D_ADDR = '0; bus.D_WR = 1'b0;
    bus.M_ACK = 1'b0;
    step(); step(); step();
    check("rst_outs", {23'd0, bus.I_GNT, bus.I_DONE, bus.I_ERR, bus.D_GNT, bus.D_DONE,
                       bus.D_ERR, bus.M_REQ, bus.M_WR, busy}, 32'd0);
    check("rst_maddr", bus.M_ADDR, 32'd0);
    mon_en = 1'b1;
    HRESETn = 1'b1;
    step();

    hit_xact(1'b0, 32'h1000_0040, 1'b0);
    miss_xact(1'b1, 32'h1010_0000, 1'b1);
    miss_xact(1'b1, 32'h2000_0000, 1'b0);
    hit_xact(1'b1, 32'h100F_FFFF, 1'b1);

    // Raised BASE applies at the next CHK: lower-bound miss, then exact-base hit.
    base_r = 20'h10010;
    miss_xact(1'b0, 32'h1000_FFF0, 1'b0);
    hit_xact(1'b0, 32'h1001_0000, 1'b0);
    base_r = 20'h10000;

    // Reset mid-XFER of a data access; late M_ACK must not produce DONE.
    c = cyc;
    push(c + 1, E_DG, '0, 1'b0);
    push(c + 2, E_RISE, 32'h1000_0100, 1'b1);
    push(c + 3, E_FALL, '0, 1'b0);
    drive_req(1'b1, 32'h1000_0100, 1'b1);
    step();
    drop_req();
    step();
    HRESETn = 1'b0;
    step();
    check("abort_outs", {23'd0, bus.I_GNT, bus.I_DONE, bus.I_ERR, bus.D_GNT, bus.D_DONE,
                         bus.D_ERR, bus.M_REQ, bus.M_WR, busy}, 32'd0);
    check("abort_maddr", bus.M_ADDR, 32'd0);
    HRESETn = 1'b1;
    step();
    step();
    bus.M_ACK = 1'b1;
    step();
    bus.M_ACK = 1'b0;
    step(); step();
    check("abort_busy", {31'd0, busy}, 32'd0);

    // Both held: I first (pointer cleared by reset), then alternate.
    c = cyc;
    for (int n = 0; n < 4; n++) begin
      bit d;
      d = (n % 2) == 1;
      push(c + 4*n + 1, d ? E_DG : E_IG, '0, 1'b0);
      push(c + 4*n + 2, E_RISE, d ? 32'h1000_0100 : 32'h1000_0040, d);
      push(c + 4*n + 3, (d ? E_DD : E_ID) | E_FALL, '0, 1'b0);
    end
    bus.I_REQ = 1'b1; bus.I_ADDR = 32'h1000_0040;
    bus.D_REQ = 1'b1; bus.D_ADDR = 32'h1000_0100; bus.D_WR = 1'b1;
    bus.M_ACK = 1'b1;
    for (int i = 0; i < 13; i++) step();
    drop_req();
    step(); step(); step();
    bus.M_ACK = 1'b0;
    step();

    // M_ACK never comes.
    c = cyc;
    push(c + 1, E_IG, '0, 1'b0);
    push(c + 2, E_RISE, 32'h1000_0040, 1'b0);
`ifdef LMI_DRAM_ARB_TMO_EN
    push(c + 257, E_ID | E_IE | E_FALL, '0, 1'b0);
    drive_req(1'b0, 32'h1000_0040, 1'b0);
    step();
    drop_req();
    for (int i = 0; i < 258; i++) step();
    check("tmo_busy", {31'd0, busy}, 32'd0);
`else
    begin
      bit held;
      held = 1'b1;
      drive_req(1'b0, 32'h1000_0040, 1'b0);
      step();
      drop_req();
      step();
      for (int i = 0; i < 1000; i++) begin
        if (bus.M_REQ !== 1'b1) held = 1'b0;
        step();
      end
      check("mreq_hold_1000", {31'd0, held}, 32'd1);
      push(c + 1003, E_ID | E_FALL, '0, 1'b0);
      bus.M_ACK = 1'b1;
      step();
      bus.M_ACK = 1'b0;
      step();
    end
`endif

    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    check("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
